cm3_in_hold_stage: RTL and testbench
====================================

Name: cm3_in_hold_stage

Overview:
- Per-master input stage of the cm3 bus matrix, directly upstream of the output stages.
- Captures an AHB address phase from one master bus. It either passes the transfer straight through, or holds it in a register while the target output stage is busy.
- Generates held_tran_op for the output-stage arbiters, and returns HREADYOUTS/HRESPS to the master.

Parameters:
ADDR_WIDTH, 32, width of HADDRS/addr_op
USER_WIDTH, 32, width of HAUSERS/auser_op
WDOG_WIDTH, 8, width of the hold-watchdog counter (used only with the optional feature)

Ports:
HCLK  input  1  AHB clock
HRESETn  input  1  async active-low reset
HSELS  input  1  slave-port select from master decode
HADDRS  input  ADDR_WIDTH  address
HAUSERS  input  USER_WIDTH  address user bus
HTRANSS  input  2  transfer type
HWRITES  input  1  direction
HSIZES  input  3  size
HBURSTS  input  3  burst
HPROTS  input  4  protection
HMASTERS  input  4  master ID
HMASTLOCKS  input  1  lock
HREADYS  input  1  master-bus HREADY
active_ip  input  1  an output stage has granted this port's address phase
readyout_ip  input  1  HREADYMUX of the output stage granting/serving this port
resp_ip  input  1  HRESP from that output stage
sel_op, addr_op, auser_op, trans_op, write_op, size_op, burst_op, prot_op, master_op, mastlock_op  output  matching widths  address/control to output stages
held_tran_op  output  1  valid transfer request
HREADYOUTS  output  1  ready to master
HRESPS  output  1  response to master
hold_timeout  output  1  sticky watchdog flag (tied 0 without the optional feature)

Behaviour:
- Reset: HRESETn, asynchronous, active-low; clock HCLK.
  - On reset, pending=0, data_phase=0 and all hold registers=0.
  - Resulting outputs: HREADYOUTS=1, HRESPS=0, hold_timeout=0.
- Definitions:
  - new_tran = HSELS & HREADYS & HTRANSS[1].
  - accept = held_tran_op & active_ip & readyout_ip.
- held_tran_op = pending | new_tran (combinational).
- Output mux:
  - pending=1: all *_op outputs come from the hold registers; sel_op=1.
  - pending=0: *_op outputs pass the live HSELS/HADDRS/... values through (zero latency).
- Hold register:
  - Loads all address/control fields when new_tran & ~accept.
  - pending is set the next edge.
  - pending clears on the edge where accept=1.
  - new_tran cannot occur while pending=1, because HREADYOUTS=0 stalls the master.
- data_phase: updates only when (~data_phase | readyout_ip), taking the value accept; otherwise it holds.
- HREADYOUTS: 0 if pending; else readyout_ip if data_phase; else 1.
- HRESPS: resp_ip if data_phase, else 0.
  - The ERROR two-cycle response passes through unchanged.
- States:
  - IDLE (pending=0, data_phase=0)
  - HOLD (pending=1)
  - DATA (data_phase=1, pending=0)
- Transitions:
  - IDLE→DATA: new_tran&accept.
  - IDLE→HOLD: new_tran&~accept.
  - HOLD→DATA: accept.
  - DATA→DATA: readyout_ip&accept (back-to-back).
  - DATA→HOLD: readyout_ip&new_tran&~accept.
  - DATA→IDLE: readyout_ip&~held_tran_op.
- IDLE/BUSY transfers never set pending or data_phase.
- Reset mid-HOLD or mid-DATA: the pending transfer is discarded; no request is issued after release.

Optional Feature:
- Macro CM3_IN_HOLD_WDOG_EN.
- Defined:
  - A WDOG_WIDTH counter clears when pending=0 and increments each cycle pending=1, saturating at all-ones.
  - hold_timeout is set when the counter reaches all-ones, and stays set (sticky) until reset.
- Undefined: no counter is built; hold_timeout=0 constantly.

Test Plan:
- Reset release, bus idle -> HREADYOUTS=1, HRESPS=0, held_tran_op=0, hold_timeout=0.
- NONSEQ write 0x2000_0010 with active_ip=1, readyout_ip=1 -> addr_op=0x2000_0010 in the same cycle, no hold; next cycle HREADYOUTS follows readyout_ip.
- NONSEQ to 0x4000_0000 with active_ip=0 for 3 cycles -> pending=1; addr_op stays 0x4000_0000 while HADDRS changes; HREADYOUTS=0 for 3 cycles; accept on cycle 4 -> DATA.
- Back-to-back SEQ burst of 4 with readyout_ip low 1 cycle on beat 2 -> HREADYOUTS low exactly 1 cycle; 4 accepts; data_phase returns to 0 after beat 4.
- resp_ip=1 for 2 cycles in DATA (readyout_ip 0 then 1) -> HRESPS=1 for both cycles, HREADYOUTS=0 then 1.
- With CM3_IN_HOLD_WDOG_EN and WDOG_WIDTH=4: active_ip=0 for 16 cycles -> hold_timeout=1 and it stays 1 after accept; without the macro it stays 0.

Source files
------------

// File: rtl/cm3_in_hold_stage_if.sv
// cm3 bus matrix: master-side AHB address/control bundle for one input stage.
// The master modport drives the address phase and sees the ready/response
// returned by the input stage. The slave modport is the input stage's view.
interface cm3_in_hold_stage_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int USER_WIDTH = 32
);
   logic                  HSELS;
   logic [ADDR_WIDTH-1:0] HADDRS;
   logic [USER_WIDTH-1:0] HAUSERS;
   logic [1:0]            HTRANSS;
   logic                  HWRITES;
   logic [2:0]            HSIZES;
   logic [2:0]            HBURSTS;
   logic [3:0]            HPROTS;
   logic [3:0]            HMASTERS;
   logic                  HMASTLOCKS;
   logic                  HREADYS;
   logic                  HREADYOUTS;
   logic                  HRESPS;

   modport master (
      output HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS,
             HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
      input  HREADYOUTS, HRESPS
   );

   modport slave (
      input  HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS,
             HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
      output HREADYOUTS, HRESPS
   );
endinterface

// File: rtl/cm3_in_hold_stage.sv
// cm3 bus matrix input stage for one master port.
// Passes an AHB address phase straight through to the output stages, or holds
// it in a register while the granting output stage is busy, and returns the
// data-phase ready/response to the master.
// Optional feature: define CM3_IN_HOLD_WDOG_EN to build a hold watchdog that
// raises a sticky hold_timeout when a transfer stays held for 2**WDOG_WIDTH-1
// cycles. Without the macro hold_timeout is tied low.
module cm3_in_hold_stage #(
   parameter int ADDR_WIDTH = 32,
   parameter int USER_WIDTH = 32,
   parameter int WDOG_WIDTH = 8
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   cm3_in_hold_stage_if.slave    s_bus,
   input  logic                  active_ip,
   input  logic                  readyout_ip,
   input  logic                  resp_ip,
   output logic                  sel_op,
   output logic [ADDR_WIDTH-1:0] addr_op,
   output logic [USER_WIDTH-1:0] auser_op,
   output logic [1:0]            trans_op,
   output logic                  write_op,
   output logic [2:0]            size_op,
   output logic [2:0]            burst_op,
   output logic [3:0]            prot_op,
   output logic [3:0]            master_op,
   output logic                  mastlock_op,
   output logic                  held_tran_op,
   output logic                  hold_timeout
);

   // Address/control fields captured into the hold register.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [USER_WIDTH-1:0] auser;
      logic [1:0]            trans;
      logic                  write;
      logic [2:0]            size;
      logic [2:0]            burst;
      logic [3:0]            prot;
      logic [3:0]            master;
      logic                  mastlock;
   } addr_phase_t;

   // State bits are {pending, data_phase}. The two flags follow independent
   // update rules, so ST_HOLD_DATA exists for the case where a master with
   // HREADYS high issues a new transfer while this port's data phase is still
   // being stalled by the output stage.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_DATA      = 2'b01,
      ST_HOLD      = 2'b10,
      ST_HOLD_DATA = 2'b11
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   addr_phase_t r_hold;
   addr_phase_t w_live;
   logic        w_pending;
   logic        w_data_phase;
   logic        w_new_tran;
   logic        w_accept;
   logic        w_pending_nxt;
   logic        w_data_nxt;

   assign w_pending    = r_state[1];
   assign w_data_phase = r_state[0];

   // Only NONSEQ/SEQ transfers on a ready, selected bus are real requests.
   assign w_new_tran   = s_bus.HSELS & s_bus.HREADYS & s_bus.HTRANSS[1];
   assign held_tran_op = w_pending | w_new_tran;
   assign w_accept     = held_tran_op & active_ip & readyout_ip;

   assign w_live = '{
      addr:     s_bus.HADDRS,
      auser:    s_bus.HAUSERS,
      trans:    s_bus.HTRANSS,
      write:    s_bus.HWRITES,
      size:     s_bus.HSIZES,
      burst:    s_bus.HBURSTS,
      prot:     s_bus.HPROTS,
      master:   s_bus.HMASTERS,
      mastlock: s_bus.HMASTLOCKS
   };

   // State register: pending and data_phase flags.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block ordering.
         r_state <= w_state_nxt;
      end
   end

   // Next state and master-facing ready/response.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      w_pending_nxt    = 1'b0;
      w_data_nxt       = w_data_phase;
      s_bus.HREADYOUTS = 1'b1;
      s_bus.HRESPS     = 1'b0;

      // A request is pending until an output stage accepts it.
      w_pending_nxt = held_tran_op & ~w_accept;

      // The data-phase flag only advances once the current data phase completes.
      if (!w_data_phase || readyout_ip) begin
         w_data_nxt = w_accept;
      end

      if (w_pending) begin
         s_bus.HREADYOUTS = 1'b0;
      end else if (w_data_phase) begin
         s_bus.HREADYOUTS = readyout_ip;
      end

      // Both cycles of an ERROR response pass through unchanged.
      if (w_data_phase) begin
         s_bus.HRESPS = resp_ip;
      end

      w_state_nxt = state_t'({w_pending_nxt, w_data_nxt});
   end

   // Hold register: capture the address phase that could not be accepted.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         // NOTE: the hold register is reset even though it is only read while
         // pending, so outputs are deterministic straight out of reset.
         r_hold <= '0;
      end else if (w_new_tran && !w_accept) begin
         r_hold <= w_live;
      end
   end

   // Output mux: held copy while pending, otherwise zero-latency pass-through.
   always_comb begin
      sel_op      = s_bus.HSELS;
      addr_op     = w_live.addr;
      auser_op    = w_live.auser;
      trans_op    = w_live.trans;
      write_op    = w_live.write;
      size_op     = w_live.size;
      burst_op    = w_live.burst;
      prot_op     = w_live.prot;
      master_op   = w_live.master;
      mastlock_op = w_live.mastlock;
      if (w_pending) begin
         sel_op      = 1'b1;
         addr_op     = r_hold.addr;
         auser_op    = r_hold.auser;
         trans_op    = r_hold.trans;
         write_op    = r_hold.write;
         size_op     = r_hold.size;
         burst_op    = r_hold.burst;
         prot_op     = r_hold.prot;
         master_op   = r_hold.master;
         mastlock_op = r_hold.mastlock;
      end
   end

   // A zero-width watchdog counter makes no sense in either build.
   if (WDOG_WIDTH < 1) begin : g_wdog_width_check
      $error("cm3_in_hold_stage: WDOG_WIDTH must be at least 1");
   end

`ifdef CM3_IN_HOLD_WDOG_EN
   logic [WDOG_WIDTH-1:0] r_wdog_cnt;
   logic [WDOG_WIDTH-1:0] w_wdog_nxt;
   logic                  r_hold_timeout;

   // Count held cycles, clearing as soon as nothing is pending; saturates.
   always_comb begin
      w_wdog_nxt = '0;
      if (w_pending) begin
         w_wdog_nxt = (&r_wdog_cnt) ? r_wdog_cnt : r_wdog_cnt + 1'b1;
      end
   end

   // Watchdog counter and sticky timeout flag, set as the count hits all-ones.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_wdog_cnt     <= '0;
         r_hold_timeout <= 1'b0;
      end else begin
         r_wdog_cnt     <= w_wdog_nxt;
         r_hold_timeout <= r_hold_timeout | (&w_wdog_nxt);
      end
   end

   assign hold_timeout = r_hold_timeout;
`else
   assign hold_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cm3_in_hold_stage.sv
// Directed self-checking bench for cm3_in_hold_stage.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling
// edge. The watchdog is built with WDOG_WIDTH=4 so the timeout checks apply
// when CM3_IN_HOLD_WDOG_EN is defined.
module tb_cm3_in_hold_stage;
   localparam int AW = 32;
   localparam int UW = 32;
`ifdef CM3_IN_HOLD_WDOG_EN
   localparam logic EXP_TIMEOUT = 1'b1;
`else
   localparam logic EXP_TIMEOUT = 1'b0;
`endif

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          active_ip;
   logic          readyout_ip;
   logic          resp_ip;
   logic          sel_op;
   logic [AW-1:0] addr_op;
   logic [UW-1:0] auser_op;
   logic [1:0]    trans_op;
   logic          write_op;
   logic [2:0]    size_op;
   logic [2:0]    burst_op;
   logic [3:0]    prot_op;
   logic [3:0]    master_op;
   logic          mastlock_op;
   logic          held_tran_op;
   logic          hold_timeout;

   int n_checks = 0;
   int n_errors = 0;

   cm3_in_hold_stage_if #(.ADDR_WIDTH(AW), .USER_WIDTH(UW)) bus ();

   cm3_in_hold_stage #(.ADDR_WIDTH(AW), .USER_WIDTH(UW), .WDOG_WIDTH(4)) dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .s_bus        (bus.slave),
      .active_ip    (active_ip),
      .readyout_ip  (readyout_ip),
      .resp_ip      (resp_ip),
      .sel_op       (sel_op),
      .addr_op      (addr_op),
      .auser_op     (auser_op),
      .trans_op     (trans_op),
      .write_op     (write_op),
      .size_op      (size_op),
      .burst_op     (burst_op),
      .prot_op      (prot_op),
      .master_op    (master_op),
      .mastlock_op  (mastlock_op),
      .held_tran_op (held_tran_op),
      .hold_timeout (hold_timeout)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.HSELS      = 1'b0;
      bus.HADDRS     = '0;
      bus.HAUSERS    = '0;
      bus.HTRANSS    = 2'b00;
      bus.HWRITES    = 1'b0;
      bus.HSIZES     = 3'd0;
      bus.HBURSTS    = 3'd0;
      bus.HPROTS     = 4'd0;
      bus.HMASTERS   = 4'd0;
      bus.HMASTLOCKS = 1'b0;
      bus.HREADYS    = 1'b1;
   endtask

   task automatic drive_tran(input logic [31:0] a, input logic [1:0] t, input logic w);
      bus.HSELS      = 1'b1;
      bus.HADDRS     = a;
      bus.HAUSERS    = ~a;
      bus.HTRANSS    = t;
      bus.HWRITES    = w;
      bus.HSIZES     = 3'd2;
      bus.HBURSTS    = 3'd3;
      bus.HPROTS     = 4'b0011;
      bus.HMASTERS   = 4'd5;
      bus.HMASTLOCKS = 1'b0;
      bus.HREADYS    = 1'b1;
   endtask

   task automatic sample();
      @(negedge HCLK);
   endtask

   task automatic next_cycle();
      @(posedge HCLK);
      #1;
   endtask

   task automatic check_ready_resp(input string tag, input logic rdy, input logic rsp);
      check({tag, "_hreadyout"}, 64'(bus.HREADYOUTS), 64'(rdy));
      check({tag, "_hresp"}, 64'(bus.HRESPS), 64'(rsp));
   endtask

   initial begin
      drive_idle();
      active_ip   = 1'b0;
      readyout_ip = 1'b1;
      resp_ip     = 1'b0;

      // Reset state, during and after reset.
      sample();
      check_ready_resp("rst", 1'b1, 1'b0);
      check("rst_held", 64'(held_tran_op), 64'd0);
      check("rst_timeout", 64'(hold_timeout), 64'd0);
      next_cycle();
      HRESETn = 1'b1;
      sample();
      check_ready_resp("post_rst", 1'b1, 1'b0);
      check("post_rst_held", 64'(held_tran_op), 64'd0);
      next_cycle();

      // Pass-through NONSEQ write accepted in the same cycle.
      drive_tran(32'h2000_0010, 2'b10, 1'b1);
      active_ip = 1'b1;
      sample();
      check("pt_addr", 64'(addr_op), 64'h2000_0010);
      check("pt_sel", 64'(sel_op), 64'd1);
      check("pt_write", 64'(write_op), 64'd1);
      check("pt_held", 64'(held_tran_op), 64'd1);
      check_ready_resp("pt_addr_phase", 1'b1, 1'b0);
      next_cycle();
      drive_idle();
      readyout_ip = 1'b0;
      bus.HREADYS = 1'b0;
      sample();
      check_ready_resp("pt_data_wait", 1'b0, 1'b0);
      check("pt_data_held", 64'(held_tran_op), 64'd0);
      next_cycle();
      readyout_ip = 1'b1;
      bus.HREADYS = 1'b1;
      sample();
      check_ready_resp("pt_data_done", 1'b1, 1'b0);
      next_cycle();

      // Held NONSEQ read: output stage busy, then grants on the third stall cycle.
      drive_tran(32'h4000_0000, 2'b10, 1'b0);
      active_ip = 1'b0;
      sample();
      check("hold_first_addr", 64'(addr_op), 64'h4000_0000);
      check_ready_resp("hold_first", 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         bus.HSELS   = 1'b0;
         bus.HADDRS  = 32'h5555_5550 + 32'(i);
         bus.HAUSERS = 32'h1234_0000;
         bus.HTRANSS = 2'b00;
         bus.HSIZES  = 3'd0;
         bus.HREADYS = 1'b0;
         active_ip   = (i == 2);
         sample();
         check($sformatf("hold%0d_addr", i), 64'(addr_op), 64'h4000_0000);
         check($sformatf("hold%0d_auser", i), 64'(auser_op), 64'hBFFF_FFFF);
         check($sformatf("hold%0d_sel", i), 64'(sel_op), 64'd1);
         check($sformatf("hold%0d_trans", i), 64'(trans_op), 64'd2);
         check($sformatf("hold%0d_size", i), 64'(size_op), 64'd2);
         check($sformatf("hold%0d_master", i), 64'(master_op), 64'd5);
         check($sformatf("hold%0d_held", i), 64'(held_tran_op), 64'd1);
         check_ready_resp($sformatf("hold%0d", i), 1'b0, 1'b0);
      end
      next_cycle();
      drive_idle();
      active_ip   = 1'b0;
      readyout_ip = 1'b0;
      sample();
      check("hold_released_addr", 64'(addr_op), 64'd0);
      check_ready_resp("hold_data", 1'b0, 1'b0);
      next_cycle();
      readyout_ip = 1'b1;
      next_cycle();

      // INCR4 burst, back-to-back, with one wait state on beat 2's data phase.
      active_ip = 1'b1;
      drive_tran(32'h0000_0100, 2'b10, 1'b1);
      sample();
      check("b0_addr", 64'(addr_op), 64'h100);
      check_ready_resp("b0", 1'b1, 1'b0);
      next_cycle();
      drive_tran(32'h0000_0104, 2'b11, 1'b1);
      sample();
      check("b1_addr", 64'(addr_op), 64'h104);
      check_ready_resp("b1", 1'b1, 1'b0);
      next_cycle();
      drive_tran(32'h0000_0108, 2'b11, 1'b1);
      readyout_ip = 1'b0;
      bus.HREADYS = 1'b0;
      sample();
      check_ready_resp("b2_wait", 1'b0, 1'b0);
      check("b2_wait_held", 64'(held_tran_op), 64'd0);
      next_cycle();
      readyout_ip = 1'b1;
      bus.HREADYS = 1'b1;
      sample();
      check("b2_addr", 64'(addr_op), 64'h108);
      check_ready_resp("b2", 1'b1, 1'b0);
      next_cycle();
      drive_tran(32'h0000_010C, 2'b11, 1'b1);
      sample();
      check("b3_addr", 64'(addr_op), 64'h10C);
      check_ready_resp("b3", 1'b1, 1'b0);
      next_cycle();
      drive_idle();
      sample();
      check_ready_resp("b3_data", 1'b1, 1'b0);
      next_cycle();
      readyout_ip = 1'b0;
      sample();
      check_ready_resp("burst_idle", 1'b1, 1'b0);
      next_cycle();
      readyout_ip = 1'b1;

      // Two-cycle ERROR response passes through.
      drive_tran(32'h0000_0300, 2'b10, 1'b0);
      next_cycle();
      drive_idle();
      resp_ip     = 1'b1;
      readyout_ip = 1'b0;
      bus.HREADYS = 1'b0;
      sample();
      check_ready_resp("err1", 1'b0, 1'b1);
      next_cycle();
      readyout_ip = 1'b1;
      bus.HREADYS = 1'b1;
      sample();
      check_ready_resp("err2", 1'b1, 1'b1);
      next_cycle();
      sample();
      check_ready_resp("err_after", 1'b1, 1'b0);
      next_cycle();
      resp_ip = 1'b0;

      // BUSY transfer is not a request and never stalls the master.
      active_ip = 1'b0;
      drive_tran(32'h0000_0400, 2'b01, 1'b0);
      sample();
      check("busy_held", 64'(held_tran_op), 64'd0);
      next_cycle();
      drive_idle();
      sample();
      check_ready_resp("busy_after", 1'b1, 1'b0);
      next_cycle();

      // Long hold drives the watchdog (4-bit counter) to saturation.
      drive_tran(32'h6000_0000, 2'b10, 1'b1);
      next_cycle();
      drive_idle();
      bus.HREADYS = 1'b0;
      for (int i = 0; i < 13; i++) next_cycle();
      sample();
      check("wdog_early", 64'(hold_timeout), 64'd0);
      next_cycle();
      next_cycle();
      next_cycle();
      sample();
      check("wdog_fired", 64'(hold_timeout), 64'(EXP_TIMEOUT));
      check("wdog_still_held", 64'(addr_op), 64'h6000_0000);
      next_cycle();
      active_ip = 1'b1;
      next_cycle();
      active_ip   = 1'b0;
      bus.HREADYS = 1'b1;
      sample();
      check_ready_resp("wdog_data", 1'b1, 1'b0);
      check("wdog_sticky", 64'(hold_timeout), 64'(EXP_TIMEOUT));
      next_cycle();

      // Async reset in the middle of a hold discards the transfer.
      drive_tran(32'h7000_0000, 2'b10, 1'b0);
      next_cycle();
      drive_idle();
      bus.HREADYS = 1'b0;
      sample();
      check_ready_resp("pre_rst_hold", 1'b0, 1'b0);
      HRESETn = 1'b0;
      #1;
      check_ready_resp("rst_mid_hold", 1'b1, 1'b0);
      check("rst_mid_hold_held", 64'(held_tran_op), 64'd0);
      check("rst_mid_hold_timeout", 64'(hold_timeout), 64'd0);
      next_cycle();
      HRESETn     = 1'b1;
      bus.HREADYS = 1'b1;
      active_ip   = 1'b1;
      sample();
      check("rst_release_held", 64'(held_tran_op), 64'd0);
      next_cycle();

      // Async reset in the middle of a stalled data phase.
      drive_tran(32'h7100_0000, 2'b10, 1'b0);
      next_cycle();
      drive_idle();
      readyout_ip = 1'b0;
      bus.HREADYS = 1'b0;
      sample();
      check_ready_resp("pre_rst_data", 1'b0, 1'b0);
      HRESETn = 1'b0;
      #1;
      check_ready_resp("rst_mid_data", 1'b1, 1'b0);
      next_cycle();
      HRESETn = 1'b1;
      sample();
      check_ready_resp("rst_data_release", 1'b1, 1'b0);
      check("rst_data_release_held", 64'(held_tran_op), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time limit so the bench always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete within the time limit");
      $fatal(1, "time limit reached");
   end
endmodule
